// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential compare/shift unit.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_EQ   = 4'd0,
      OP_NE   = 4'd1,
      OP_LT   = 4'd2,
      OP_GE   = 4'd3,
      OP_LTU  = 4'd4,
      OP_GEU  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10,
      OP_ROL  = 4'd11,
      OP_ROR  = 4'd12,
      OP_MIN  = 4'd13,
      OP_MAX  = 4'd14,
      OP_ILL  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int unsigned shamt_w(input int unsigned width);
      return $clog2(width);
   endfunction

   function automatic logic is_shift_op(input alu_op_e op);
      return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
   endfunction

endpackage

// File: rtl/alu_cmp_core.sv
// Combinational compare / min / max / illegal decode; shift codes yield zero.
module alu_cmp_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             illegal_o
);

   logic    eq, lt, ltu;
   alu_op_e op;

   assign op  = alu_op_e'(op_i);
   assign eq  = (a_i == b_i);
   assign lt  = ($signed(a_i) < $signed(b_i));
   assign ltu = (a_i < b_i);

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      unique case (op)
         OP_EQ:           result_o[0] = eq;
         OP_NE:           result_o[0] = ~eq;
         OP_LT, OP_SLT:   result_o[0] = lt;
         OP_GE:           result_o[0] = ~lt;
         OP_LTU, OP_SLTU: result_o[0] = ltu;
         OP_GEU:          result_o[0] = ~ltu;
         OP_MIN:          result_o    = lt ? a_i : b_i;
         OP_MAX:          result_o    = lt ? b_i : a_i;
         OP_ILL:          illegal_o   = 1'b1;
         default:         result_o    = '0;
      endcase
   end

endmodule

// File: rtl/alu_comp_seq.sv
// Handshaked compare/shift unit; shifts and rotates iterate SHIFT_STEP bits per cycle.
module alu_comp_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHIFT_STEP = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       alu_op_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             illegal_o
);

   localparam int unsigned SW = shamt_w(WIDTH);
   localparam int unsigned CW = SW + 1;

   state_e           state_q, state_d;
   alu_op_e          op_q, op_d, op_in;
   logic [SW-1:0]    rem_q, rem_d, s_in;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] cmp_result;
   logic             cmp_illegal;
   logic [CW-1:0]    rem_ext, k;
   logic [WIDTH-1:0] shifted;

   assign op_in = alu_op_e'(alu_op_i);
   assign s_in  = operand_b_i[SW-1:0];

   alu_cmp_core #(.WIDTH(WIDTH)) u_cmp (
      .op_i      (alu_op_i),
      .a_i       (operand_a_i),
      .b_i       (operand_b_i),
      .result_o  (cmp_result),
      .illegal_o (cmp_illegal)
   );

   // Step size is capped at SHIFT_STEP so the per-cycle shifter stays shallow.
   assign rem_ext = {1'b0, rem_q};
   assign k       = (rem_ext < CW'(SHIFT_STEP)) ? rem_ext : CW'(SHIFT_STEP);

   // SRA keeps the original sign: the work register's MSB never changes under >>>.
   always_comb begin
      shifted = work_q;
      unique case (op_q)
         OP_SLL:  shifted = work_q << k;
         OP_SRL:  shifted = work_q >> k;
         OP_SRA:  shifted = $signed(work_q) >>> k;
         OP_ROL:  shifted = (work_q << k) | (work_q >> (CW'(WIDTH) - k));
         OP_ROR:  shifted = (work_q >> k) | (work_q << (CW'(WIDTH) - k));
         default: shifted = work_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rem_d     = rem_q;
      work_d    = work_q;
      result_d  = result_q;
      illegal_d = illegal_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               if (is_shift_op(op_in) && (s_in != '0)) begin
                  work_d    = operand_a_i;
                  rem_d     = s_in;
                  op_d      = op_in;
                  illegal_d = 1'b0;
                  state_d   = SHIFT;
               end else begin
                  result_d  = is_shift_op(op_in) ? operand_a_i : cmp_result;
                  illegal_d = cmp_illegal;
                  state_d   = DONE;
               end
            end
         end
         SHIFT: begin
            work_d = shifted;
            rem_d  = rem_q - k[SW-1:0];
            if (rem_ext == k) begin
               result_d = shifted;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over accept, step and handshake alike.
      if (flush_i) begin
         state_d   = IDLE;
         rem_d     = '0;
         op_d      = op_q;
         work_d    = work_q;
         result_d  = result_q;
         illegal_d = illegal_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         op_q      <= OP_EQ;
         rem_q     <= '0;
         work_q    <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         work_q    <= work_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign result_o    = result_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_comp_seq.sv
// Directed bench for alu_comp_seq (WIDTH=32, SHIFT_STEP=8) with hand-computed expectations.
module tb_alu_comp_seq;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  alu_op_i;
   logic [31:0] operand_a_i;
   logic [31:0] operand_b_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic        illegal_o;

   int n_assert = 0;
   int n_fail   = 0;

   alu_comp_seq #(.WIDTH(32), .SHIFT_STEP(8)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .alu_op_i    (alu_op_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .illegal_o   (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one request and return edges from accept to out_valid_o.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      int guard = 0;
      while (!in_ready_o && guard < 50) begin
         tick();
         guard++;
      end
      alu_op_i    = op;
      operand_a_i = a;
      operand_b_i = b;
      in_valid_i  = 1'b1;
      tick();
      in_valid_i  = 1'b0;
      lat = 1;
      while (!out_valid_o && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_ill, input int exp_lat);
      int lat;
      issue(op, a, b, lat);
      check({tag, ".result"}, result_o, exp_res);
      check({tag, ".illegal"}, {31'd0, illegal_o}, {31'd0, exp_ill});
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      tick();
   endtask

   initial begin
      int          lat;
      logic [31:0] held;
      logic        seen;

      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      alu_op_i    = '0;
      operand_a_i = '0;
      operand_b_i = '0;
      out_ready_i = 1'b1;
      repeat (2) tick();
      check("rst.in_ready", {31'd0, in_ready_o}, 32'd1);
      check("rst.out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst.result", result_o, 32'd0);
      check("rst.illegal", {31'd0, illegal_o}, 32'd0);
      rst_ni = 1'b1;
      tick();

      run_op("slt",   4'd9,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1);
      run_op("sltu",  4'd10, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
      run_op("min",   4'd13, 32'hFFFF_FFFD, 32'h2,         32'hFFFF_FFFD, 1'b0, 1);
      run_op("max",   4'd14, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1);
      run_op("eq",    4'd0,  32'h1234,      32'h1234,      32'h1,         1'b0, 1);
      run_op("ne",    4'd1,  32'h1234,      32'h1234,      32'h0,         1'b0, 1);
      run_op("ge",    4'd3,  32'h8000_0000, 32'h0,         32'h0,         1'b0, 1);
      run_op("ltu",   4'd4,  32'h0,         32'h8000_0000, 32'h1,         1'b0, 1);
      run_op("geu",   4'd5,  32'h5,         32'h5,         32'h1,         1'b0, 1);
      run_op("ill",   4'd15, 32'hDEAD_BEEF, 32'h1,         32'h0,         1'b1, 1);
      run_op("sra31", 4'd8,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 5);
      run_op("srl31", 4'd7,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 5);
      run_op("sra9",  4'd8,  32'h4000_0000, 32'd9,         32'h0020_0000, 1'b0, 3);
      run_op("sllm",  4'd6,  32'h1,         32'h23,        32'h8,         1'b0, 2);
      run_op("sll0",  4'd6,  32'h1,         32'h20,        32'h1,         1'b0, 1);
      run_op("ror4",  4'd12, 32'h1,         32'd4,         32'h1000_0000, 1'b0, 2);
      run_op("rol1",  4'd11, 32'h8000_0001, 32'd1,         32'h0000_0003, 1'b0, 2);
      run_op("rol17", 4'd11, 32'h8000_0001, 32'd17,        32'h0003_0000, 1'b0, 4);
      run_op("ror16", 4'd12, 32'h1234_5678, 32'd16,        32'h5678_1234, 1'b0, 3);

      // Backpressure: result held while consumer stalls.
      out_ready_i = 1'b0;
      issue(4'd13, 32'h8000_0000, 32'h7, lat);
      check("bp.result", result_o, 32'h8000_0000);
      held = result_o;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp.hold_result", result_o, held);
         check("bp.hold_valid", {31'd0, out_valid_o}, 32'd1);
         check("bp.in_ready", {31'd0, in_ready_o}, 32'd0);
         check("bp.illegal", {31'd0, illegal_o}, 32'd0);
      end
      out_ready_i = 1'b1;
      tick();
      check("bp.idle_valid", {31'd0, out_valid_o}, 32'd0);
      check("bp.idle_ready", {31'd0, in_ready_o}, 32'd1);
      alu_op_i    = 4'd0;
      operand_a_i = 32'h9;
      operand_b_i = 32'h9;
      in_valid_i  = 1'b1;
      tick();
      in_valid_i  = 1'b0;
      check("b2b.valid", {31'd0, out_valid_o}, 32'd1);
      check("b2b.result", result_o, 32'h1);
      tick();

      // Flush in the second SHIFT cycle of SRA s=31.
      alu_op_i    = 4'd8;
      operand_a_i = 32'h8000_0000;
      operand_b_i = 32'd31;
      in_valid_i  = 1'b1;
      tick();
      in_valid_i  = 1'b0;
      check("fl.busy", {31'd0, in_ready_o}, 32'd0);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("fl.in_ready", {31'd0, in_ready_o}, 32'd1);
      check("fl.out_valid", {31'd0, out_valid_o}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen |= out_valid_o;
      end
      check("fl.no_result", {31'd0, seen}, 32'd0);

      // Flush together with a request in IDLE: request dropped.
      in_valid_i = 1'b1;
      flush_i    = 1'b1;
      alu_op_i   = 4'd0;
      tick();
      in_valid_i = 1'b0;
      flush_i    = 1'b0;
      check("flv.in_ready", {31'd0, in_ready_o}, 32'd1);
      check("flv.out_valid", {31'd0, out_valid_o}, 32'd0);

      // Reset mid-SHIFT.
      alu_op_i    = 4'd8;
      operand_a_i = 32'h8000_0000;
      operand_b_i = 32'd31;
      in_valid_i  = 1'b1;
      tick();
      in_valid_i  = 1'b0;
      tick();
      rst_ni = 1'b0;
      #1;
      check("mrst.in_ready", {31'd0, in_ready_o}, 32'd1);
      check("mrst.out_valid", {31'd0, out_valid_o}, 32'd0);
      check("mrst.result", result_o, 32'd0);
      check("mrst.illegal", {31'd0, illegal_o}, 32'd0);
      tick();
      rst_ni = 1'b1;
      tick();
      run_op("post", 4'd11, 32'h0000_000F, 32'd28, 32'hF000_0000, 1'b0, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_comp_seq.md
# alu_comp_seq

Parametrised, handshaked successor to the team's combinational compare/shift unit. Executes comparisons, min/max, logical/arithmetic shifts and rotates on WIDTH-bit operands. Shifts and rotates run iteratively at SHIFT_STEP bits per cycle to bound the shifter's logic depth. Sits between the execute-stage operand mux and the writeback/branch-resolve logic, with a valid/ready handshake on each side.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 4.
- SHIFT_STEP, 8: maximum bits shifted per cycle; power of two, 1..WIDTH.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- flush_i  in  1  synchronous abort of any in-flight operation.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- alu_op_i  in  4  operation code (see Operation).
- operand_a_i  in  WIDTH  source / shifted value.
- operand_b_i  in  WIDTH  second operand / shift amount.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  WIDTH  result; compare results zero-extended to 1 bit.
- illegal_o  out  1  qualified by out_valid_o; op code 15 was issued.

## Operation
- Op codes: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 ROL, 12 ROR, 13 MIN (signed), 14 MAX (signed), 15 illegal (result 0, illegal_o=1).
- Shift/rotate amount s = operand_b_i[$clog2(WIDTH)-1:0]; upper bits ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready_o=1. Accept on in_valid_i && in_ready_o. Non-shift op, or shift/rotate with s==0: result registered, go DONE. Shift/rotate with s>0: load operand_a_i into work register, rem=s, latch op, go SHIFT.
- SHIFT: each cycle shift/rotate work register by k=min(rem, SHIFT_STEP), rem-=k. SRA fills with the original sign bit; SLL/SRL fill zeros; ROL/ROR wrap. When rem reaches 0, go DONE.
- DONE: out_valid_o=1; result_o, illegal_o held stable until out_ready_i. Handshake: go IDLE. in_ready_o=0 in SHIFT and DONE.
- flush_i has priority over every transition: next state IDLE, out_valid_o=0, in-flight op discarded. flush_i and in_valid_i in the same IDLE cycle: request is not accepted.

## Timing
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, result_o=0, illegal_o=0, rem=0.
- Latency L counts clock edges from the accept edge to out_valid_o rising: L=1 for compare/min/max/illegal and for s==0; L=1+ceil(s/SHIFT_STEP) otherwise.
- Throughput: one bubble cycle after each output handshake (IDLE re-entry). Non-shift peak is one op every 2 cycles.
- Outputs are registered; no combinational path from inputs to out_valid_o or result_o. in_ready_o depends only on state.
- Reset asserted mid-operation: immediate return to reset values. No result is produced for the aborted op.

## Structure
- Package alu_pkg: alu_op_e enum (4-bit codes above), state_e enum {IDLE, SHIFT, DONE}, and a helper function for the clog2 shift-amount width.
- Sub-module alu_cmp_core: combinational EQ/NE/LT/GE/LTU/GEU/SLT/SLTU/MIN/MAX/illegal decode, WIDTH-parametrised. The top block holds the FSM, work register, rem counter and output registers.

## Test plan
- WIDTH=32, SHIFT_STEP=8: SLT a=0xFFFFFFFF b=0x1 → result 1, L=1; SLTU same operands → 0; MIN a=0xFFFFFFFD b=2 → 0xFFFFFFFD; op 15 → result 0, illegal_o=1.
- SRA a=0x80000000 b=31 → 0xFFFFFFFF, L=5; SRL same → 0x00000001, L=5.
- SLL a=0x1 b=0x23 (amount masked to 3) → 0x8, L=2. SLL b=0x20 (s=0) → 0x1, L=1.
- ROR a=0x1 b=4 → 0x10000000. ROL a=0x80000001 b=1 → 0x00000003. ROL b=17 with SHIFT_STEP=8 → correct result, L=4.
- Backpressure: out_ready_i=0 for 3 cycles in DONE → result_o/illegal_o stable, in_ready_o=0. Handshake → IDLE next edge; a back-to-back request is accepted the cycle after.
- Abort: flush_i in second SHIFT cycle of SRA s=31 → next cycle IDLE, in_ready_o=1, no out_valid_o. Repeat with rst_ni low mid-SHIFT → reset values immediately.
